ahb_arbiter: RTL
================

# ahb_arbiter

- Centralised AHB bus arbiter that shares the single AHB address/data path, and therefore the slave interfaces behind it, between up to NUM_MASTERS requesting masters.
- Samples per-master bus requests and lock requests, and tracks fixed-length bursts with a beat counter so that a burst is never broken.
- Drives a registered one-hot grant, the address-phase owner index (hmaster) and hmastlock to the master/slave multiplexers.
- Sits alongside the address decoder, between the masters and the slave side of the bus.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- DEFAULT_MASTER, 0: master granted when nobody requests.

Ports:
- hclk  in  1  bus clock; single clock, all state on rising edge.
- hresetn  in  1  reset; synchronous, active-low.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-transfer request.
- htrans  in  2  muxed transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed burst type of the current owner.
- hready  in  1  bus ready from the slave mux.
- hgrant  out  NUM_MASTERS  one-hot registered grant.
- hmaster  out  $clog2(NUM_MASTERS)  index of the address-phase owner.
- hmastlock  out  1  current address phase is locked.

## Operation
States: IDLE, BUSY, LOCKED.
- IDLE: no hbusreq is asserted and DEFAULT_MASTER is granted.
- BUSY: the granted master owns the bus.
- LOCKED: the granted master's hlock was sampled with its grant.

Beat counter (4 bits, beats_left):
- Loads on an accepted NONSEQ (hready=1): SINGLE→0, INCR4/WRAP4→3, INCR8/WRAP8→7, INCR16/WRAP16→15.
- Decrements on each accepted SEQ, saturating at 0.
- INCR (undefined length) loads 0, so every beat is a boundary.

rearb_ok = hready && state!=LOCKED && (htrans==IDLE || htrans==BUSY-free boundary, i.e. htrans==IDLE or the accepted beat leaves beats_left==0).

When rearb_ok is true:
- The winner among hbusreq is chosen per the Configuration section.
- If there are no requests, DEFAULT_MASTER wins.

State transitions:
- Winner requesting → BUSY, or LOCKED if hlock[winner]=1.
- No requests → IDLE.
- LOCKED → BUSY or IDLE only when hlock[owner]=0 and the rearb_ok conditions, ignoring the lock, hold. While LOCKED, hgrant is frozen.
- hready=0 freezes hgrant, hmaster, hmastlock, beats_left and state.
- An owner that deasserts hbusreq mid fixed-burst keeps the grant until the burst completes.

## Timing
- Reset (hresetn=0 at an edge): hgrant=one-hot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmastlock=0, beats_left=0, state=IDLE. Round-robin pointer=DEFAULT_MASTER.
- Reset asserted mid-burst or mid-lock overrides everything on that edge.
- Grant latency:
  - A request sampled in a rearb_ok cycle sets hgrant on the next edge.
  - An idle bus request → hgrant at edge +1.
- hmaster and hmastlock load from the granted index and hlock[granted] on every edge with hready=1. They therefore lag hgrant by one accepted address phase.
- Simultaneous requests are resolved in the same cycle. Exactly one hgrant bit is set at all times.

## Configuration
- AHB_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration.
  - The search starts at last_winner+1 and wraps modulo NUM_MASTERS.
  - last_winner updates whenever a requesting master is newly granted.
- Not defined:
  - Fixed priority; the lowest index wins.
  - No pointer register exists.

## Structure
- Shared package ahb_pkg holds:
  - the HTRANS_* constants (IDLE/BUSY/NONSEQ/SEQ);
  - the HBURST_* constants (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16);
  - the arbiter state enum.
- One sub-module is natural: ahb_arb_pick.
  - Purely combinational.
  - Inputs: request vector and start pointer.
  - Output: one-hot winner plus a valid flag.
  - Fixed priority is the case start=0.

## Test plan
- Reset: hresetn=0 for 2 cycles, NUM_MASTERS=4, DEFAULT_MASTER=0 → hgrant=4'b0001, hmaster=0, hmastlock=0.
- Simultaneous requests:
  - hbusreq=4'b0110 with htrans=IDLE and hready=1 → hgrant=4'b0010 at the next edge.
  - With ROUND_ROBIN_EN, after master 1 drops → hgrant=4'b0100, then master 2 stays granted while it requests.
- INCR4 burst:
  - Master 1 issues NONSEQ INCR4 and master 3 requests throughout → grant unchanged through SEQ beats 1–2.
  - hgrant=4'b1000 at the edge after the 4th beat is accepted.
- Locked transfer:
  - Master 2 with hlock=1 → hmastlock=1 after its first accepted address phase.
  - Other requests are ignored until hlock[2]=0 and a boundary; grant then moves.
- hready=0 stall:
  - Hold hready low for 3 cycles during a burst with competing requests → hgrant, hmaster and beats_left are unchanged.
  - Progress resumes when hready returns high.
- No requests: hbusreq drops to 0 → state IDLE and hgrant=4'b0001 at the next boundary edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer/burst encodings, arbiter state type and
// small decode helpers used by the bus arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY   = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    // Beats remaining after the NONSEQ beat; undefined-length INCR counts as single.
    function automatic logic [3:0] burst_load(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
            HBURST_WRAP16, HBURST_INCR16: return 4'd15;
            default:                      return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational rotating-priority picker: first requester at or after
// 'start' (wrapping) wins; start = 0 gives plain lowest-index priority.
module ahb_arb_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic         valid
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_grant;
    logic [2*N-1:0] grant2;

    // Rotate so 'start' sits at bit 0, isolate lowest set bit, rotate back.
    assign req2      = {req, req} >> start;
    assign rot       = req2[N-1:0];
    assign rot_grant = rot & (-rot);
    assign grant2    = {rot_grant, rot_grant} << start;
    assign grant     = grant2[2*N-1:N];
    assign valid     = |req;

endmodule

// File: rtl/ahb_arbiter.sv
// Centralised AHB arbiter with burst tracking and locked transfers.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    localparam int IDXW = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [IDXW-1:0]        hmaster,
    output logic                   hmastlock
);

    localparam logic [IDXW-1:0]        DEF_IDX   = IDXW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [3:0]             beats_left_q, beats_left_d;
    logic [IDXW-1:0]        grant_idx;
    logic                   owner_lock;
    logic                   accepted_beat;
    logic                   boundary;
    logic                   rearb_ok;
    logic [IDXW-1:0]        start;
    logic [NUM_MASTERS-1:0] win_grant;
    logic                   win_valid;
    logic                   win_lock;

    assign grant_idx     = IDXW'(onehot_idx(16'(hgrant)));
    assign owner_lock    = |(hlock & hgrant);
    assign accepted_beat = hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

    always_comb begin
        beats_left_d = beats_left_q;
        if (hready && htrans == HTRANS_NONSEQ)
            beats_left_d = burst_load(hburst);
        else if (hready && htrans == HTRANS_SEQ && beats_left_q != 4'd0)
            beats_left_d = beats_left_q - 4'd1;
    end

    // A locked owner releases only once it drops hlock at a burst boundary.
    assign boundary = (htrans == HTRANS_IDLE) || (accepted_beat && beats_left_d == 4'd0);
    assign rearb_ok = hready && boundary && (state_q != ARB_LOCKED || !owner_lock);

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] last_winner_q;

    assign start = (last_winner_q == IDXW'(NUM_MASTERS - 1)) ? '0 : last_winner_q + IDXW'(1);

    always_ff @(posedge hclk) begin
        if (!hresetn)
            last_winner_q <= DEF_IDX;
        else if (rearb_ok && win_valid)
            last_winner_q <= IDXW'(onehot_idx(16'(win_grant)));
    end
`else
    assign start = '0;
`endif

    ahb_arb_pick #(.N(NUM_MASTERS)) u_pick (
        .req   (hbusreq),
        .start (start),
        .grant (win_grant),
        .valid (win_valid)
    );

    assign win_lock = |(hlock & win_grant);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d = state_q;
        grant_d = hgrant;
        if (rearb_ok) begin
            if (win_valid) begin
                grant_d = win_grant;
                state_d = win_lock ? ARB_LOCKED : ARB_BUSY;
            end else begin
                grant_d = DEF_GRANT;
                state_d = ARB_IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q      <= ARB_IDLE;
            hgrant       <= DEF_GRANT;
            hmaster      <= DEF_IDX;
            hmastlock    <= 1'b0;
            beats_left_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            hgrant       <= grant_d;
            beats_left_q <= beats_left_d;
            if (hready) begin
                hmaster   <= grant_idx;
                hmastlock <= owner_lock;
            end
        end
    end

endmodule
